bram_dp_wmask_pipe: RTL and testbench

- Parametrised true-dual-port synchronous RAM for accelerator private local memories.
- Generalises the fixed 8192x2 dual-port wrapper in four ways:
  - configurable width and depth;
  - per-bit write mask honoured on both ports;
  - selectable read-during-write mode and optional output register;
  - post-reset zero-initialisation sweep with a READY flag.
- Sits between PLM controllers and inferred or vendor block RAM; one clock domain for both ports.

---
 rtl/bram_dp_wmask_pipe.sv | 176 +++++++++++++++++
 tb/tb_bram_dp_wmask_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_dp_wmask_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bram_dp_wmask_pipe
// Brief    : Parametrised true-dual-port synchronous RAM with per-bit write
//            masks, selectable same-port read-during-write behaviour, an
//            optional output register and a post-reset zero/INIT_VAL sweep.
// Revision : 1.0 - initial release
// ============================================================================
module bram_dp_wmask_pipe #(
    parameter int                 DATA_W     = 2,
    parameter int                 ADDR_W     = 13,
    parameter int                 WRITE_MODE = 0,
    parameter int                 OUT_REG    = 0,
    parameter int                 INIT_EN    = 1,
    parameter logic [DATA_W-1:0]  INIT_VAL   = '0
) (
    input  logic              CLK,
    input  logic              RSTN,
    output logic              READY,
    input  logic [ADDR_W-1:0] A0,
    input  logic [DATA_W-1:0] D0,
    input  logic              WE0,
    input  logic [DATA_W-1:0] WEM0,
    input  logic              CE0,
    output logic [DATA_W-1:0] Q0,
    output logic              VLD0,
    input  logic [ADDR_W-1:0] A1,
    input  logic [DATA_W-1:0] D1,
    input  logic              WE1,
    input  logic [DATA_W-1:0] WEM1,
    input  logic              CE1,
    output logic [DATA_W-1:0] Q1,
    output logic              VLD1
);

    localparam int              c_DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST    = {ADDR_W{1'b1}};
    localparam logic [0:0]      c_SWEEP     = 1'b0;
    localparam logic [0:0]      c_RUN       = 1'b1;
    localparam logic [0:0]      c_RST_STATE = (INIT_EN != 0) ? c_SWEEP : c_RUN;
    localparam bit              c_WR_FIRST  = (WRITE_MODE == 1);
    localparam bit              c_NO_CHANGE = (WRITE_MODE == 2);

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    // Distinguishes "out of reset for at least one edge" so READY stays low
    // throughout reset even when the sweep is disabled.
    logic              r_live;

    // Per-port views so both ports share one description.
    logic [1:0][ADDR_W-1:0] w_a;
    logic [1:0][DATA_W-1:0] w_d;
    logic [1:0][DATA_W-1:0] w_wem;
    logic [1:0]             w_ce;
    logic [1:0]             w_we;
    logic [1:0]             w_wr;
    logic [1:0]             w_rd;
    logic [DATA_W-1:0]      w_old   [2];
    logic [DATA_W-1:0]      w_merge [2];
    logic [DATA_W-1:0]      w_rdata [2];
    logic [DATA_W-1:0]      w_q     [2];
    logic [1:0]             w_v;
    logic                   w_coll;
    logic [DATA_W-1:0]      w_merge_both;

    assign w_a   = {A1, A0};
    assign w_d   = {D1, D0};
    assign w_wem = {WEM1, WEM0};
    assign w_ce  = {CE1, CE0};
    assign w_we  = {WE1, WE0};

    assign READY = r_live & (r_state == c_RUN);

    // Sweep sequencer: walk every address once after reset, then run.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= c_RST_STATE;
            r_cnt   <= '0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (r_state == c_SWEEP) begin
                r_cnt <= r_cnt + ADDR_W'(1);
                if (r_cnt == c_LAST) begin
                    r_state <= c_RUN;
                end
            end
        end
    end

    // Same-address dual write: port 0 owns its masked bits, port 1 fills the
    // bits port 0 leaves alone, everything else keeps the old value.
    assign w_coll       = w_wr[0] & w_wr[1] & (w_a[0] == w_a[1]);
    assign w_merge_both = (w_old[0] & ~(w_wem[0] | w_wem[1]))
                        | (w_d[0] & w_wem[0])
                        | (w_d[1] & w_wem[1] & ~w_wem[0]);

    // Memory update: sweep fill, or masked port writes once running.
    always_ff @(posedge CLK) begin
        if (RSTN && (r_state == c_SWEEP)) begin
            r_mem[r_cnt] <= INIT_VAL;
        end else if (w_coll) begin
            r_mem[w_a[0]] <= w_merge_both;
        end else begin
            if (w_wr[0]) begin
                r_mem[w_a[0]] <= w_merge[0];
            end
            if (w_wr[1]) begin
                r_mem[w_a[1]] <= w_merge[1];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_port
            logic [DATA_W-1:0] r_s1_q;
            logic              r_s1_v;

            assign w_old[g]   = r_mem[w_a[g]];
            assign w_merge[g] = (w_old[g] & ~w_wem[g]) | (w_d[g] & w_wem[g]);
            assign w_wr[g]    = READY & w_ce[g] & w_we[g];
            // In NO_CHANGE a write access is not also a read.
            assign w_rd[g]    = READY & w_ce[g] & ~(c_NO_CHANGE & w_we[g]);
            // WRITE_FIRST shows this port's own merged word; the other port's
            // same-cycle write is never visible to this read.
            assign w_rdata[g] = (c_WR_FIRST && w_we[g]) ? w_merge[g] : w_old[g];

            // Read stage 1: capture the word on every read, hold otherwise.
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    r_s1_q <= '0;
                    r_s1_v <= 1'b0;
                end else begin
                    r_s1_v <= w_rd[g];
                    if (w_rd[g]) begin
                        r_s1_q <= w_rdata[g];
                    end
                end
            end

            if (OUT_REG != 0) begin : g_oreg
                logic [DATA_W-1:0] r_s2_q;
                logic              r_s2_v;

                // Read stage 2: forward only valid stage-1 data.
                always_ff @(posedge CLK or negedge RSTN) begin
                    if (!RSTN) begin
                        r_s2_q <= '0;
                        r_s2_v <= 1'b0;
                    end else begin
                        r_s2_v <= r_s1_v;
                        if (r_s1_v) begin
                            r_s2_q <= r_s1_q;
                        end
                    end
                end

                assign w_q[g] = r_s2_q;
                assign w_v[g] = r_s2_v;
            end else begin : g_noreg
                assign w_q[g] = r_s1_q;
                assign w_v[g] = r_s1_v;
            end
        end
    endgenerate

    assign Q0   = w_q[0];
    assign VLD0 = w_v[0];
    assign Q1   = w_q[1];
    assign VLD1 = w_v[1];

endmodule
`default_nettype wire

// File: tb/tb_bram_dp_wmask_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_dp_wmask_pipe
// Brief    : Directed-vector bench for bram_dp_wmask_pipe. Three instances
//            (READ_FIRST/latency 1, WRITE_FIRST/latency 2, NO_CHANGE/latency 1)
//            share one stimulus stream; a behavioural model tracks all three.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_dp_wmask_pipe;

    typedef struct {
        logic       ce0;
        logic       we0;
        logic [3:0] a0;
        logic [7:0] d0;
        logic [7:0] m0;
        logic       ce1;
        logic       we1;
        logic [3:0] a1;
        logic [7:0] d1;
        logic [7:0] m1;
        logic [7:0] eq0;
        logic       ev0;
        logic [7:0] eq1;
        logic       ev1;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1, m0, m1;
    logic       ce0, ce1, we0, we1;

    logic [2:0]      rdy;
    logic [2:0][7:0] q0, q1;
    logic [2:0]      v0, v1;

    int wm_k[3]   = '{0, 1, 2};
    int oreg_k[3] = '{0, 1, 0};

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_mem [16];
    logic [7:0] e_s1q [3][2];
    logic [7:0] e_s2q [3][2];
    logic       e_s1v [3][2];
    logic       e_s2v [3][2];
    int         n_rd  [3][2];
    int         n_vld [3][2];

    vec_t tbl [15];

    always #5 clk = ~clk;

    bram_dp_wmask_pipe #(.DATA_W(8), .ADDR_W(4), .WRITE_MODE(0), .OUT_REG(0),
                         .INIT_EN(1), .INIT_VAL(8'hA5)) u_rf (
        .CLK(clk), .RSTN(rstn), .READY(rdy[0]),
        .A0(a0), .D0(d0), .WE0(we0), .WEM0(m0), .CE0(ce0), .Q0(q0[0]), .VLD0(v0[0]),
        .A1(a1), .D1(d1), .WE1(we1), .WEM1(m1), .CE1(ce1), .Q1(q1[0]), .VLD1(v1[0]));

    bram_dp_wmask_pipe #(.DATA_W(8), .ADDR_W(4), .WRITE_MODE(1), .OUT_REG(1),
                         .INIT_EN(1), .INIT_VAL(8'hA5)) u_wf (
        .CLK(clk), .RSTN(rstn), .READY(rdy[1]),
        .A0(a0), .D0(d0), .WE0(we0), .WEM0(m0), .CE0(ce0), .Q0(q0[1]), .VLD0(v0[1]),
        .A1(a1), .D1(d1), .WE1(we1), .WEM1(m1), .CE1(ce1), .Q1(q1[1]), .VLD1(v1[1]));

    bram_dp_wmask_pipe #(.DATA_W(8), .ADDR_W(4), .WRITE_MODE(2), .OUT_REG(0),
                         .INIT_EN(1), .INIT_VAL(8'hA5)) u_nc (
        .CLK(clk), .RSTN(rstn), .READY(rdy[2]),
        .A0(a0), .D0(d0), .WE0(we0), .WEM0(m0), .CE0(ce0), .Q0(q0[2]), .VLD0(v0[2]),
        .A1(a1), .D1(d1), .WE1(we1), .WEM1(m1), .CE1(ce1), .Q1(q1[2]), .VLD1(v1[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        ce0 = 1'b0; we0 = 1'b0; a0 = '0; d0 = '0; m0 = '0;
        ce1 = 1'b0; we1 = 1'b0; a1 = '0; d1 = '0; m1 = '0;
    endtask

    // Advance the model by one access cycle using the inputs currently driven.
    task automatic model_step();
        logic [7:0] old [2];
        old[0] = m_mem[a0];
        old[1] = m_mem[a1];
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                logic       c, w, rd;
                logic [7:0] d, m;
                c = (p == 0) ? ce0 : ce1;
                w = (p == 0) ? we0 : we1;
                d = (p == 0) ? d0 : d1;
                m = (p == 0) ? m0 : m1;
                if (e_s1v[k][p]) e_s2q[k][p] = e_s1q[k][p];
                e_s2v[k][p] = e_s1v[k][p];
                rd = c && !(w && wm_k[k] == 2);
                if (rd) begin
                    n_rd[k][p]++;
                    e_s1v[k][p] = 1'b1;
                    if (wm_k[k] == 1 && w) begin
                        for (int b = 0; b < 8; b++)
                            e_s1q[k][p][b] = m[b] ? d[b] : old[p][b];
                    end else begin
                        e_s1q[k][p] = old[p];
                    end
                end else begin
                    e_s1v[k][p] = 1'b0;
                end
            end
        end
        for (int b = 0; b < 8; b++) begin
            if (ce0 && we0 && m0[b]) m_mem[a0][b] = d0[b];
            if (ce1 && we1 && m1[b] && !(ce0 && we0 && a0 == a1 && m0[b]))
                m_mem[a1][b] = d1[b];
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                logic [7:0] eq, aq;
                logic       ev, av;
                eq = (oreg_k[k] != 0) ? e_s2q[k][p] : e_s1q[k][p];
                ev = (oreg_k[k] != 0) ? e_s2v[k][p] : e_s1v[k][p];
                aq = (p == 0) ? q0[k] : q1[k];
                av = (p == 0) ? v0[k] : v1[k];
                if (av === 1'b1) n_vld[k][p]++;
                chk($sformatf("model inst%0d Q%0d", k, p), 32'(aq), 32'(eq));
                chk($sformatf("model inst%0d VLD%0d", k, p), 32'(av), 32'(ev));
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        // ce0 we0 a0 d0 m0 | ce1 we1 a1 d1 m1 | Q0 VLD0 Q1 VLD1 (READ_FIRST, latency 1)
        tbl[0]  = '{1'b1,1'b1,4'd3,8'hFF,8'hFF, 1'b0,1'b0,4'd0,8'h00,8'h00, 8'hA5,1'b1, 8'hA5,1'b0};
        tbl[1]  = '{1'b1,1'b1,4'd3,8'h00,8'h0F, 1'b0,1'b0,4'd0,8'h00,8'h00, 8'hFF,1'b1, 8'hA5,1'b0};
        tbl[2]  = '{1'b1,1'b0,4'd3,8'h00,8'h00, 1'b0,1'b0,4'd0,8'h00,8'h00, 8'hF0,1'b1, 8'hA5,1'b0};
        tbl[3]  = '{1'b0,1'b0,4'd0,8'h00,8'h00, 1'b0,1'b0,4'd0,8'h00,8'h00, 8'hF0,1'b0, 8'hA5,1'b0};
        tbl[4]  = '{1'b1,1'b1,4'd5,8'h11,8'hFF, 1'b0,1'b0,4'd0,8'h00,8'h00, 8'hA5,1'b1, 8'hA5,1'b0};
        tbl[5]  = '{1'b1,1'b1,4'd5,8'h22,8'hFF, 1'b0,1'b0,4'd0,8'h00,8'h00, 8'h11,1'b1, 8'hA5,1'b0};
        tbl[6]  = '{1'b1,1'b0,4'd5,8'h00,8'h00, 1'b0,1'b0,4'd0,8'h00,8'h00, 8'h22,1'b1, 8'hA5,1'b0};
        tbl[7]  = '{1'b1,1'b1,4'd9,8'h00,8'hFF, 1'b0,1'b0,4'd0,8'h00,8'h00, 8'hA5,1'b1, 8'hA5,1'b0};
        tbl[8]  = '{1'b1,1'b1,4'd9,8'h3C,8'hFF, 1'b1,1'b0,4'd9,8'h00,8'h00, 8'h00,1'b1, 8'h00,1'b1};
        tbl[9]  = '{1'b0,1'b0,4'd0,8'h00,8'h00, 1'b1,1'b0,4'd9,8'h00,8'h00, 8'h00,1'b0, 8'h3C,1'b1};
        tbl[10] = '{1'b1,1'b1,4'd2,8'h00,8'hFF, 1'b1,1'b1,4'd2,8'h00,8'hFF, 8'hA5,1'b1, 8'hA5,1'b1};
        tbl[11] = '{1'b1,1'b1,4'd2,8'hAA,8'hF0, 1'b1,1'b1,4'd2,8'h55,8'hFF, 8'h00,1'b1, 8'h00,1'b1};
        tbl[12] = '{1'b1,1'b0,4'd2,8'h00,8'h00, 1'b1,1'b0,4'd2,8'h00,8'h00, 8'hA5,1'b1, 8'hA5,1'b1};
        tbl[13] = '{1'b1,1'b1,4'd7,8'hFF,8'h00, 1'b0,1'b0,4'd0,8'h00,8'h00, 8'hA5,1'b1, 8'hA5,1'b0};
        tbl[14] = '{1'b1,1'b0,4'd7,8'h00,8'h00, 1'b0,1'b0,4'd0,8'h00,8'h00, 8'hA5,1'b1, 8'hA5,1'b0};

        set_idle();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset READY inst%0d", k), 32'(rdy[k]), 32'd0);
            chk($sformatf("reset Q0 inst%0d", k), 32'(q0[k]), 32'd0);
            chk($sformatf("reset VLD1 inst%0d", k), 32'(v1[k]), 32'd0);
        end

        // Sweep aborted at cycle 7 by a reset pulse.
        rstn = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("aborted sweep READY c%0d", i), 32'(rdy), 32'd0);
        end
        rstn = 1'b0;
        #1;
        chk("READY during reassert", 32'(rdy), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Full sweep with accesses presented that must be ignored.
        ce0 = 1'b1; we0 = 1'b1; a0 = 4'd0; d0 = 8'h00; m0 = 8'hFF;
        ce1 = 1'b1; we1 = 1'b0; a1 = 4'd1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("sweep READY c%0d", i), 32'(rdy), (i == 16) ? 32'h7 : 32'h0);
            chk($sformatf("sweep VLD c%0d", i), 32'({v0, v1}), 32'd0);
            chk($sformatf("sweep Q0 hold c%0d", i), 32'(q0[0]), 32'd0);
        end
        set_idle();

        for (int i = 0; i < 16; i++) m_mem[i] = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                e_s1q[k][p] = '0; e_s2q[k][p] = '0;
                e_s1v[k][p] = 1'b0; e_s2v[k][p] = 1'b0;
            end
        end

        // Every word reads back as the sweep value.
        for (int i = 0; i < 16; i++) begin
            ce0 = 1'b1; a0 = 4'(i);
            ce1 = 1'b1; a1 = 4'(15 - i);
            tick();
            chk($sformatf("init word P0 a%0d", i), 32'(q0[0]), 32'hA5);
            chk($sformatf("init word P1 a%0d", 15 - i), 32'(q1[0]), 32'hA5);
        end
        set_idle();
        tick();

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            ce0 = tbl[i].ce0; we0 = tbl[i].we0; a0 = tbl[i].a0; d0 = tbl[i].d0; m0 = tbl[i].m0;
            ce1 = tbl[i].ce1; we1 = tbl[i].we1; a1 = tbl[i].a1; d1 = tbl[i].d1; m1 = tbl[i].m1;
            tick();
            chk($sformatf("vec%0d Q0", i),   32'(q0[0]), 32'(tbl[i].eq0));
            chk($sformatf("vec%0d VLD0", i), 32'(v0[0]), 32'(tbl[i].ev0));
            chk($sformatf("vec%0d Q1", i),   32'(q1[0]), 32'(tbl[i].eq1));
            chk($sformatf("vec%0d VLD1", i), 32'(v1[0]), 32'(tbl[i].ev1));
            // Hand-derived corner checks on the WRITE_FIRST/latency-2 and NO_CHANGE instances.
            if (i == 3) begin
                chk("wf lat2 Q0 masked", 32'(q0[1]), 32'hF0);
                chk("wf lat2 VLD0 high", 32'(v0[1]), 32'd1);
            end
            if (i == 4) chk("wf lat2 VLD0 drop", 32'(v0[1]), 32'd0);
            if (i == 5) begin
                chk("nc Q0 hold", 32'(q0[2]), 32'hF0);
                chk("nc VLD0 low", 32'(v0[2]), 32'd0);
            end
            if (i == 6) begin
                chk("wf Q0 new word", 32'(q0[1]), 32'h22);
                chk("wf VLD0", 32'(v0[1]), 32'd1);
            end
        end
        set_idle();
        tick();

        // Random streaming on both ports.
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                n_rd[k][p] = 0; n_vld[k][p] = 0;
            end
        end
        for (int c = 0; c < 2000; c++) begin
            ce0 = ($urandom_range(0, 3) != 0); we0 = 1'($urandom_range(0, 1));
            a0  = 4'($urandom_range(0, 7)); d0 = 8'($urandom); m0 = 8'($urandom);
            ce1 = ($urandom_range(0, 3) != 0); we1 = 1'($urandom_range(0, 1));
            a1  = 4'($urandom_range(0, 7)); d1 = 8'($urandom); m1 = 8'($urandom);
            tick();
        end
        set_idle();
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("vld count inst%0d P%0d", k, p), 32'(n_vld[k][p]), 32'(n_rd[k][p]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
